// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SB_DEPTH   = 3;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JAL    = 2'd1,
    PC_BRANCH = 2'd2
  } pc_src_t;

  typedef logic [2:0] pipe_state_t;
  localparam pipe_state_t ST_INIT   = 3'd0;
  localparam pipe_state_t ST_RUN    = 3'd1;
  localparam pipe_state_t ST_RAW    = 3'd2;
  localparam pipe_state_t ST_MEMW   = 3'd3;
  localparam pipe_state_t ST_BRPEND = 3'd4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

  function automatic logic sb_hit(input sb_entry_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid && (e.rd == r);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// rtl/pipeline_ctrl_scoreboard.sv - in-flight destination tracker for EX/MEM/WB
// Shifts with the pipeline and flags RAW hazards on the ID-stage source operands.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_advance,
  input  logic                  i_kill,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_we,
  input  logic                  i_id_valid,
  input  logic [ADDR_WIDTH-1:0] i_rs1,
  input  logic                  i_rs1_used,
  input  logic [ADDR_WIDTH-1:0] i_rs2,
  input  logic                  i_rs2_used,
  output logic                  o_raw
);

  sb_entry_t r_sb_ex, r_sb_mem, r_sb_wb;
  sb_entry_t w_new;
  logic      w_hit1, w_hit2;
  logic [REG_ADDR_W-1:0] w_rs1, w_rs2;

  assign w_new.valid = i_load && i_we && (i_rd != '0);
  assign w_new.rd    = REG_ADDR_W'(i_rd);
  assign w_rs1       = REG_ADDR_W'(i_rs1);
  assign w_rs2       = REG_ADDR_W'(i_rs2);

  // i_kill drops the wrong-path instruction leaving EX when a branch resolves
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sb_ex  <= '0;
      r_sb_mem <= '0;
      r_sb_wb  <= '0;
    end else if (i_advance) begin
      r_sb_wb  <= r_sb_mem;
      r_sb_mem <= i_kill ? '0 : r_sb_ex;
      r_sb_ex  <= w_new;
    end
  end

  assign w_hit1 = sb_hit(r_sb_ex, w_rs1) || sb_hit(r_sb_mem, w_rs1) ||
                  (!WB_BYPASS && sb_hit(r_sb_wb, w_rs1));
  assign w_hit2 = sb_hit(r_sb_ex, w_rs2) || sb_hit(r_sb_mem, w_rs2) ||
                  (!WB_BYPASS && sb_hit(r_sb_wb, w_rs2));

  assign o_raw = i_id_valid &&
                 ((i_rs1_used && (i_rs1 != '0) && w_hit1) ||
                  (i_rs2_used && (i_rs2 != '0) && w_hit2));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage core
// Holds the FSM, the per-cycle priority resolution and the performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter bit WB_BYPASS  = 1'b1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_rs1_i,
  input  logic                  id_rs1_used_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                  id_rs2_used_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  input  logic                  id_reg_we_i,
  input  logic                  id_jal_i,
  input  logic                  mem_branch_i,
  input  logic                  mem_stall_i,
  output logic [1:0]            pc_src_o,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  id_ex_en_o,
  output logic                  ex_mem_en_o,
  output logic                  mem_wb_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  pipe_state_t          r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
  logic                 w_raw, w_br, w_run, w_advance, w_load;
  logic                 w_stall_evt, w_flush_evt;
  pc_src_t              w_pc_src;

  // A branch seen during a memory stall is remembered by the BRPEND state itself
  assign w_br      = mem_branch_i || (r_state == ST_BRPEND);
  assign w_run     = (r_state != ST_INIT) && !mem_stall_i;
  assign w_advance = w_run;
  assign w_load    = id_valid_i && !w_br && !w_raw;

  hazard_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WB_BYPASS (WB_BYPASS)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_advance (w_advance),
    .i_kill    (w_br),
    .i_load    (w_load),
    .i_rd      (id_rd_i),
    .i_we      (id_reg_we_i),
    .i_id_valid(id_valid_i),
    .i_rs1     (id_rs1_i),
    .i_rs1_used(id_rs1_used_i),
    .i_rs2     (id_rs2_i),
    .i_rs2_used(id_rs2_used_i),
    .o_raw     (w_raw)
  );

  always_comb begin
    w_pc_src       = PC_SEQ;
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    if (r_state == ST_INIT) begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = '0;
      {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o}              = '1;
    end else if (mem_stall_i) begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = '0;
    end else if (w_br) begin
      w_pc_src = PC_BRANCH;
      {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o} = '1;
    end else if (w_raw) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (id_jal_i) begin
      w_pc_src      = PC_JAL;
      if_id_flush_o = 1'b1;
    end
  end

  assign pc_src_o    = w_pc_src;
  assign w_stall_evt = (r_state != ST_INIT) && (mem_stall_i || (!w_br && w_raw));
  assign w_flush_evt = w_run && (w_br || (!w_raw && id_jal_i));

  always_comb begin
    w_state_nxt = ST_RUN;
    if (r_state == ST_INIT)
      w_state_nxt = ST_RUN;
    else if (mem_stall_i)
      w_state_nxt = w_br ? ST_BRPEND : ST_MEMW;
    else if (!w_br && w_raw)
      w_state_nxt = ST_RAW;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_INIT;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed vector bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       id_valid_i = 1'b0, id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
  logic [4:0] id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic       id_reg_we_i = 1'b0, id_jal_i = 1'b0, mem_branch_i = 1'b0, mem_stall_i = 1'b0;

  logic [1:0]  pc1, pc0;
  logic [4:0]  en1, en0;
  logic [2:0]  fl1, fl0;
  logic [31:0] sc1, fc1, sc0, fc0;
  logic [9:0]  out1, out0;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [9:0] E_INIT = 10'b00_00000_111;
  localparam logic [9:0] E_RUN  = 10'b00_11111_000;
  localparam logic [9:0] E_RAW  = 10'b00_00111_010;
  localparam logic [9:0] E_JAL  = 10'b01_11111_100;
  localparam logic [9:0] E_BR   = 10'b10_11111_111;
  localparam logic [9:0] E_MEMW = 10'b00_00000_000;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl #(.ADDR_WIDTH(5), .WB_BYPASS(1'b1), .CNT_WIDTH(32)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_i(id_rs2_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_reg_we_i(id_reg_we_i), .id_jal_i(id_jal_i),
    .mem_branch_i(mem_branch_i), .mem_stall_i(mem_stall_i), .pc_src_o(pc1),
    .pc_en_o(en1[4]), .if_id_en_o(en1[3]), .id_ex_en_o(en1[2]),
    .ex_mem_en_o(en1[1]), .mem_wb_en_o(en1[0]),
    .if_id_flush_o(fl1[2]), .id_ex_flush_o(fl1[1]), .ex_mem_flush_o(fl1[0]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  pipeline_ctrl #(.ADDR_WIDTH(5), .WB_BYPASS(1'b0), .CNT_WIDTH(32)) u_dut_nobyp (
    .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_i(id_rs2_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_reg_we_i(id_reg_we_i), .id_jal_i(id_jal_i),
    .mem_branch_i(mem_branch_i), .mem_stall_i(mem_stall_i), .pc_src_o(pc0),
    .pc_en_o(en0[4]), .if_id_en_o(en0[3]), .id_ex_en_o(en0[2]),
    .ex_mem_en_o(en0[1]), .mem_wb_en_o(en0[0]),
    .if_id_flush_o(fl0[2]), .id_ex_flush_o(fl0[1]), .ex_mem_flush_o(fl0[0]),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  assign out1 = {pc1, en1, fl1};
  assign out0 = {pc0, en0, fl0};

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       jal;
    logic       br;
    logic       ms;
    logic [9:0] exp;
    int         sc;
    int         fc;
  } vec_t;

  function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                              input logic u2, input int rd, input logic we, input logic jal,
                              input logic br, input logic ms, input logic [9:0] e,
                              input int sc, input int fc);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2;
    t.rd = 5'(rd); t.we = we; t.jal = jal; t.br = br; t.ms = ms;
    t.exp = e; t.sc = sc; t.fc = fc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid_i = t.v; id_rs1_i = t.rs1; id_rs1_used_i = t.u1;
    id_rs2_i = t.rs2; id_rs2_used_i = t.u2; id_rd_i = t.rd;
    id_reg_we_i = t.we; id_jal_i = t.jal; mem_branch_i = t.br; mem_stall_i = t.ms;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_out", 32'(out1), 32'(E_INIT));
    chk("rst_stall_cnt", sc1, 0);
    chk("rst_flush_cnt", fc1, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("init_out", 32'(out1), 32'(E_INIT));
    @(posedge clk_i); #1;
  endtask

  // Applies one vector, checks the bypass DUT between edges, then clocks it in
  task automatic step(input vec_t t, input string nm);
    drive(t);
    @(negedge clk_i);
    chk({nm, "_out"}, 32'(out1), 32'(t.exp));
    chk({nm, "_scnt"}, sc1, 32'(t.sc));
    chk({nm, "_fcnt"}, fc1, 32'(t.fc));
    @(posedge clk_i); #1;
  endtask

  vec_t tbl[19];
  vec_t prod, cons;

  initial begin
    tbl[0]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, E_RUN,  0, 0);
    tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_RAW,  0, 0);
    tbl[2]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_RAW,  1, 0);
    tbl[3]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_RUN,  2, 0);
    tbl[4]  = mk(1, 3, 1, 4, 1, 0, 1, 0, 0, 0, E_RUN,  2, 0);
    tbl[5]  = mk(1, 0, 1, 0, 1, 7, 1, 0, 0, 0, E_RUN,  2, 0);
    tbl[6]  = mk(1, 7, 0, 7, 0, 1, 1, 1, 0, 0, E_JAL,  2, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,  2, 1);
    tbl[8]  = mk(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, E_RAW,  2, 1);
    tbl[9]  = mk(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, E_JAL,  3, 1);
    tbl[10] = mk(1, 4, 1, 0, 0, 3, 1, 0, 0, 0, E_RUN,  3, 2);
    tbl[11] = mk(1, 3, 1, 0, 0, 9, 1, 1, 1, 0, E_BR,   3, 2);
    tbl[12] = mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, E_RUN,  3, 3);
    tbl[13] = mk(1, 4, 1, 0, 0, 8, 1, 0, 0, 1, E_MEMW, 3, 3);
    tbl[14] = mk(1, 4, 1, 0, 0, 8, 1, 0, 1, 1, E_MEMW, 4, 3);
    tbl[15] = mk(1, 4, 1, 0, 0, 8, 1, 0, 0, 1, E_MEMW, 5, 3);
    tbl[16] = mk(1, 4, 1, 0, 0, 8, 1, 0, 0, 1, E_MEMW, 6, 3);
    tbl[17] = mk(1, 4, 1, 0, 0, 8, 1, 0, 0, 0, E_BR,   7, 3);
    tbl[18] = mk(1, 4, 1, 0, 0, 8, 1, 0, 0, 0, E_RUN,  7, 4);

    do_reset();
    for (int i = 0; i < 19; i++) step(tbl[i], $sformatf("v%0d", i));

    // Without WB bypass the consumer waits a third cycle for the WB-stage writer
    do_reset();
    prod = tbl[0];
    cons = tbl[1];
    step(prod, "nb_prod");
    for (int k = 0; k < 4; k++) begin
      drive(cons);
      @(negedge clk_i);
      chk($sformatf("nb_cons%0d_out", k), 32'(out0), (k < 3) ? 32'(E_RAW) : 32'(E_RUN));
      @(posedge clk_i); #1;
    end
    chk("nb_stall_cnt", sc0, 3);
    for (int k = 0; k < 2; k++) begin
      drive((k == 0) ? mk(1, 3, 1, 4, 1, 0, 1, 0, 0, 0, E_RUN, 0, 0)
                     : mk(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, E_RUN, 0, 0));
      @(negedge clk_i);
      chk($sformatf("nb_x0_%0d_out", k), 32'(out0), 32'(E_RUN));
      @(posedge clk_i); #1;
    end
    chk("nb_x0_stall_cnt", sc0, 3);

    // Asynchronous reset while a RAW stall is in progress
    do_reset();
    step(prod, "rr_prod");
    step(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_RAW, 0, 0), "rr_cons");
    rst_ni = 1'b0;
    #1;
    chk("rr_async_out", 32'(out1), 32'(E_INIT));
    chk("rr_async_scnt", sc1, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rr_init_out", 32'(out1), 32'(E_INIT));
    @(posedge clk_i); #1;
    step(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, E_RUN, 0, 0), "rr_run");

    // A branch latched during a memory stall must not survive reset
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_MEMW, 0, 0), "bp_latch");
    rst_ni = 1'b0;
    idle();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("bp_init_out", 32'(out1), 32'(E_INIT));
    @(posedge clk_i); #1;
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0), "bp_run");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
